// File: rtl/dram_cmd_responder_pkg.sv
// Shared DDR3 command codes, geometry defaults and state type for the BRAM-backed DRAM responder.
package dram_cmd_responder_pkg;

  localparam int unsigned DdrCWidth   = 3;
  localparam int unsigned DdrAWidth   = 28;
  localparam int unsigned DdrDWidth   = 512;
  localparam int unsigned DdrBstLen   = 8;
  localparam int unsigned MemDepthLg  = 10;
  localparam int unsigned RdLatency   = 4;
  localparam int unsigned RdQueDepth  = 8;

  localparam logic [DdrCWidth-1:0] Ddr3CmdWrite = 3'b000;
  localparam logic [DdrCWidth-1:0] Ddr3CmdRead  = 3'b001;

  typedef enum logic [0:0] {StInit, StReady} init_state_e;

  function automatic int unsigned log2_ceil(input int unsigned v);
    return $clog2(v);
  endfunction

endpackage

// File: rtl/dram_rd_fifo.sv
// First-word-fall-through read-return FIFO; output data is forced to zero while empty.
module dram_rd_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] store_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop_i && (cnt_q != '0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign push_ok = push_i && ((cnt_q != FullCnt) || pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) store_q[wptr_q] <= push_data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? store_q[rptr_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/dram_cmd_responder.sv
// BRAM-backed DRAM stand-in: clears memory after reset, stores write bursts and returns
// read bursts in accept order after a fixed latency, with credit-based flow control.
module dram_cmd_responder
  import dram_cmd_responder_pkg::*;
#(
  parameter int unsigned DDRAWidth   = DdrAWidth,
  parameter int unsigned DDRDWidth   = DdrDWidth,
  parameter int unsigned DDRBstLen   = DdrBstLen,
  parameter int unsigned MemDepthLog = MemDepthLg,
  parameter int unsigned ReadLatency = RdLatency,
  parameter int unsigned RdQDepth    = RdQueDepth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DdrCWidth-1:0] cmd_i,
  input  logic [DDRAWidth-1:0] addr_i,
  input  logic [DDRDWidth-1:0] write_data_i,
  input  logic                 write_data_valid_i,
  output logic                 write_data_ready_o,
  output logic [DDRDWidth-1:0] read_data_o,
  output logic                 read_data_valid_o,
  input  logic                 read_data_ready_i,
  output logic                 init_done_o,
  output logic                 addr_error_o,
  output logic                 cmd_error_o
);
  localparam int unsigned BstLog  = log2_ceil(DDRBstLen);
  localparam int unsigned MemSize = 2 ** MemDepthLog;
  localparam int unsigned CntW    = $clog2(RdQDepth) + 1;
  localparam int unsigned PipeLen = ReadLatency - 1;
  localparam logic [CntW-1:0] CreditMax = CntW'(RdQDepth);

  init_state_e            state_q;
  logic [MemDepthLog-1:0] ptr_q;
  logic                   init_done_q;

  logic                   is_write, is_read, cmd_acc, wr_acc, rd_acc, pop;
  logic [MemDepthLog-1:0] idx;
  logic                   misaligned, unused_addr_hi;

  logic [DDRDWidth-1:0]   mem_q [MemSize];
  logic                   mem_we;
  logic [MemDepthLog-1:0] mem_waddr;
  logic [DDRDWidth-1:0]   mem_wdata;

  logic [PipeLen-1:0]     pipe_vld_q;
  logic [DDRDWidth-1:0]   pipe_data_q [PipeLen];

  logic [CntW-1:0]        outst_q, outst_d, fifo_cnt;
  logic                   addr_err_q, addr_err_d, cmd_err_q, cmd_err_d;

  assign is_write       = (cmd_i == Ddr3CmdWrite);
  assign is_read        = (cmd_i == Ddr3CmdRead);
  assign idx            = addr_i[MemDepthLog+BstLog-1:BstLog];
  assign misaligned     = |addr_i[BstLog-1:0];
  assign unused_addr_hi = ^addr_i[DDRAWidth-1:MemDepthLog+BstLog];

  // Credit counts every in-flight read, so one limit keeps both pipe and FIFO from overflowing.
  assign cmd_ready_o = (state_q == StReady) && (outst_q < CreditMax) &&
                       (!is_write || write_data_valid_i);
  assign cmd_acc            = cmd_valid_i && cmd_ready_o;
  assign wr_acc             = cmd_acc && is_write;
  assign rd_acc             = cmd_acc && is_read;
  assign write_data_ready_o = wr_acc;
  assign pop                = read_data_valid_o && read_data_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StInit;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          ptr_q <= ptr_q + 1'b1;
          if (&ptr_q) begin
            state_q     <= StReady;
            init_done_q <= 1'b1;
          end
        end
        StReady: state_q <= StReady;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = write_data_i;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_i) begin
    pipe_data_q[0] <= mem_q[idx];
    for (int i = 1; i < int'(PipeLen); i++) pipe_data_q[i] <= pipe_data_q[i-1];
  end

  always_comb begin
    outst_d = outst_q;
    if (rd_acc && !pop) begin
      outst_d = outst_q + 1'b1;
    end else if (!rd_acc && pop) begin
      outst_d = outst_q - 1'b1;
    end
    addr_err_d = addr_err_q | (cmd_acc && (is_read || is_write) && misaligned);
    cmd_err_d  = cmd_err_q | (cmd_acc && !is_read && !is_write);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      outst_q    <= '0;
      addr_err_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      pipe_vld_q[0] <= rd_acc;
      for (int i = 1; i < int'(PipeLen); i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      outst_q    <= outst_d;
      addr_err_q <= addr_err_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  dram_rd_fifo #(
    .Depth (RdQDepth),
    .Width (DDRDWidth)
  ) u_rd_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (pipe_vld_q[PipeLen-1]),
    .push_data_i (pipe_data_q[PipeLen-1]),
    .pop_i       (pop),
    .valid_o     (read_data_valid_o),
    .data_o      (read_data_o),
    .count_o     (fifo_cnt)
  );

  assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_cnt <= outst_q);

  assign init_done_o  = init_done_q;
  assign addr_error_o = addr_err_q;
  assign cmd_error_o  = cmd_err_q;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Directed bench for dram_cmd_responder: init sweep, write/read latency, credit, order, errors, reset.
module tb_dram_cmd_responder;

  localparam logic [2:0] CW = 3'b000;
  localparam logic [2:0] CR = 3'b001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd;
  logic [27:0]  addr;
  logic [511:0] wdata;
  logic         wdata_valid, wdata_ready;
  logic [511:0] rd_data;
  logic         rd_valid, rd_ready;
  logic         init_done, addr_err, cmd_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic last_wready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dram_cmd_responder dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .cmd_valid_i        (cmd_valid),
    .cmd_ready_o        (cmd_ready),
    .cmd_i              (cmd),
    .addr_i             (addr),
    .write_data_i       (wdata),
    .write_data_valid_i (wdata_valid),
    .write_data_ready_o (wdata_ready),
    .read_data_o        (rd_data),
    .read_data_valid_o  (rd_valid),
    .read_data_ready_i  (rd_ready),
    .init_done_o        (init_done),
    .addr_error_o       (addr_err),
    .cmd_error_o        (cmd_err)
  );

  function automatic logic [511:0] pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at any time; returns at +1 of cycle 1024 after reset release.
  task automatic reset_and_init(output int bad, output logic done_pre);
    bad = 0;
    done_pre = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      #1;
      if (cmd_ready || rd_valid) bad++;
      if (i == 1023) done_pre = init_done;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [27:0] a, input logic [511:0] d,
                      output int acc);
    int n = 0;
    cmd_valid   = 1'b1;
    cmd         = c;
    addr        = a;
    wdata       = d;
    wdata_valid = (c == CW);
    #1;
    while (!cmd_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq("send_accept", n < 50, 1'b1);
    last_wready = wdata_ready;
    acc = cyc;
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    wdata_valid = 1'b0;
  endtask

  task automatic wait_valid(input int acc, input string tag, input logic [511:0] exp);
    int n = 0;
    #1;
    while (!rd_valid && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq({tag, "_lat"}, cyc - acc, 4);
    check_eq({tag, "_data"}, rd_data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, acc_w, bad, cnt, miss, gaps, pops;
    logic done_pre;

    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd = CR; addr = 28'h40; wdata = '0; wdata_valid = 1'b0;
    rd_ready = 1'b1;
    #12;
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_rd_data", rd_data, '0);
    check_eq("rst_init_done", init_done, 1'b0);
    check_eq("rst_errs", {addr_err, cmd_err, wdata_ready}, 3'b000);

    // Init sweep with a pending read that must not be taken.
    reset_and_init(bad, done_pre);
    check_eq("init_quiet", bad, 0);
    check_eq("init_done_pre", done_pre, 1'b0);
    check_eq("init_done", init_done, 1'b1);
    send(CR, 28'h40, '0, acc);
    wait_valid(acc, "init_rd", '0);

    // Write without data must stall; then write-then-read returns fresh data.
    cmd_valid = 1'b1; cmd = CW; wdata_valid = 1'b0;
    #1 check_eq("wr_no_data", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    send(CW, 28'h80, pat(8'hA5), acc_w);
    check_eq("wr_ready", last_wready, 1'b1);
    send(CR, 28'h80, '0, acc);
    check_eq("w2r_gap", acc - acc_w, 1);
    wait_valid(acc, "w2r", pat(8'hA5));

    // Order: words 0..7 distinct, read back 7..0 back-to-back.
    for (int i = 0; i < 8; i++) send(CW, 28'(i * 8), pat(8'(8'h10 + i)), acc);
    miss = 0;
    gaps = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          cmd_valid = 1'b1; cmd = CR; addr = 28'((7 - i) * 8);
          #1;
          if (!cmd_ready) miss++;
          @(posedge clk);
          #1;
        end
        cmd_valid = 1'b0;
      end
      begin
        int n = 0;
        #1;
        while (!rd_valid && n < 20) begin
          @(posedge clk);
          #2;
          n++;
        end
        for (int k = 0; k < 8; k++) begin
          if (!rd_valid) gaps++;
          check_eq("order_data", rd_data, pat(8'(8'h17 - k)));
          @(posedge clk);
          #2;
        end
      end
    join
    check_eq("order_ready_miss", miss, 0);
    check_eq("order_gaps", gaps, 0);
    @(posedge clk);
    #1;

    // Credit: 10 back-to-back reads with consumer stalled.
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd = CR; addr = 28'h80;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cmd_ready) cnt++;
      @(posedge clk);
      #1;
    end
    check_eq("credit_accepts", cnt, 8);
    #1;
    check_eq("credit_full", cmd_ready, 1'b0);
    check_eq("credit_head", {rd_valid, rd_data}, {1'b1, pat(8'hA5)});
    rd_ready = 1'b1;
    check_eq("pop_cycle_ready", cmd_ready, 1'b0);
    @(posedge clk);
    #1 rd_ready = 1'b0;
    #1 check_eq("after_pop_ready", cmd_ready, 1'b1);
    @(posedge clk);
    #2 check_eq("refull_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    rd_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid) pops++;
      @(posedge clk);
      #2;
    end
    check_eq("credit_drain", pops, 8);
    @(posedge clk);
    #1;

    // Misaligned address aliases onto word 8; unknown command is a no-op.
    check_eq("addr_err_pre", addr_err, 1'b0);
    send(CW, 28'h43, pat(8'h3C), acc);
    #1 check_eq("addr_err_set", addr_err, 1'b1);
    send(CR, 28'h40, '0, acc);
    wait_valid(acc, "alias8", pat(8'h3C));
    check_eq("cmd_err_pre", cmd_err, 1'b0);
    send(3'b111, 28'h80, '0, acc);
    #1 check_eq("cmd_err_set", {cmd_err, addr_err}, 2'b11);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (rd_valid) cnt++;
      @(posedge clk);
      #2;
    end
    check_eq("nop_no_data", cnt, 0);
    rd_ready = 1'b0;
    cmd_valid = 1'b1; cmd = CR; addr = 28'h0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cmd_ready) cnt++;
      @(posedge clk);
      #1;
    end
    check_eq("nop_credit", cnt, 8);
    cmd_valid = 1'b0;
    rd_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Reset with reads in flight.
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(CR, 28'h80, '0, acc);
    cnt = 0;
    #1;
    while (!rd_valid && cnt < 20) begin
      @(posedge clk);
      #2;
      cnt++;
    end
    check_eq("pre_rst_valid", rd_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", rd_valid, 1'b0);
    check_eq("mid_rst_data", rd_data, '0);
    check_eq("mid_rst_flags", {init_done, addr_err, cmd_err}, 3'b000);
    reset_and_init(bad, done_pre);
    check_eq("reinit_quiet", bad, 0);
    check_eq("reinit_done", init_done, 1'b1);
    rd_ready = 1'b1;
    send(CR, 28'h80, '0, acc);
    wait_valid(acc, "post_reinit", '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
